// File: rtl/serial_word_tx_pkg.sv
// Shared encodings and helpers for the framed serial word transmitter.
package serial_word_tx_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    SH_HOLD  = 2'd0,
    SH_LOAD  = 2'd1,
    SH_SHIFT = 2'd2
  } shift_mode_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_word_tx_if.sv
// Word handshake plus serial line/status bundle between producer and transmitter.
interface serial_word_tx_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] loadval;
  logic             sdata;
  logic             busy;
  logic             done;

  modport master (output load_valid, loadval, input load_ready, sdata, busy, done);
  modport slave  (input load_valid, loadval, output load_ready, sdata, busy, done);
endinterface

// File: rtl/serial_word_tx_bit_timer.sv
// Period counter: o_bit_end marks the last enabled cycle of each BIT_CYCLES-long bit.
module serial_word_tx_bit_timer
  import serial_word_tx_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_bit_end,
  output logic o_end_next
);

  localparam int unsigned CNT_W = cnt_width(BIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  assign o_bit_end = (r_cnt == LAST);

  always_comb begin
    w_cnt_next = r_cnt;
    if (i_clr) begin
      w_cnt_next = '0;
    end else if (i_en) begin
      w_cnt_next = o_bit_end ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Lets the parent register a strobe that lines up with the last cycle of a bit.
  assign o_end_next = (w_cnt_next == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-in, serial-out framed transmitter: start bit 0, WIDTH data bits, stop bit 1.
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned LSB_FIRST  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  serial_word_tx_if.slave  bus
);

  localparam int unsigned IDX_W = cnt_width(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  shift_mode_e      w_mode;
  logic             r_sdata;
  logic             r_busy;
  logic             r_done;
  logic             w_sdata_next;
  logic             w_head;
  logic             w_load_ready;
  logic             w_accept;
  logic             w_tmr_clr;
  logic             w_bit_end;
  logic             w_end_next;

  // Ready also in the final stop cycle so a waiting word starts with no idle bit.
  assign w_load_ready = enable && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));
  assign w_accept     = bus.load_valid && w_load_ready;
  assign w_tmr_clr    = enable && (r_state == IDLE);

  serial_word_tx_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (enable),
    .i_clr      (w_tmr_clr),
    .o_bit_end  (w_bit_end),
    .o_end_next (w_end_next)
  );

  always_comb begin
    w_next_state = r_state;
    w_idx_next   = r_idx;
    w_mode       = SH_HOLD;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = START;
          w_mode       = SH_LOAD;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_next_state = DATA;
          w_idx_next   = '0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_idx == IDX_LAST) begin
            w_next_state = STOP;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
            w_mode     = SH_SHIFT;
          end
        end
      end
      default: begin
        if (w_bit_end) begin
          if (w_accept) begin
            w_next_state = START;
            w_mode       = SH_LOAD;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
    endcase
  end

  // Shift register: the head bit is always the next data bit on the line.
  always_comb begin
    w_shift_next = r_shift;
    case (w_mode)
      SH_LOAD:  w_shift_next = bus.loadval;
      SH_SHIFT: w_shift_next = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);
      default:  w_shift_next = r_shift;
    endcase
    w_head = (LSB_FIRST != 0) ? w_shift_next[0] : w_shift_next[WIDTH-1];
  end

  always_comb begin
    w_sdata_next = LINE_IDLE;
    case (w_next_state)
      START:   w_sdata_next = START_BIT;
      DATA:    w_sdata_next = w_head;
      STOP:    w_sdata_next = STOP_BIT;
      default: w_sdata_next = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_shift <= '0;
      r_sdata <= LINE_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (enable) begin
      r_state <= w_next_state;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_sdata <= w_sdata_next;
      r_busy  <= (w_next_state != IDLE);
      r_done  <= (w_next_state == STOP) && w_end_next;
    end
  end

  assign bus.load_ready = w_load_ready;
  assign bus.sdata      = r_sdata;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_serial_word_tx.sv
// Scoreboard bench for serial_word_tx over three configurations (MSB/BC1, LSB/BC1, MSB/BC4).
module tb_serial_word_tx;

  localparam int W  = 4;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic [NI-1:0] rstn;
  logic [NI-1:0] lv;
  logic [NI-1:0] en;
  logic [W-1:0]  lval [NI];
  logic [NI-1:0] w_sd;
  logic [NI-1:0] w_busy;
  logic [NI-1:0] w_done;
  logic [NI-1:0] w_rdy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q [NI][$];
  int           pos [NI];
  int           cnt [NI];
  bit           start_nx [NI];
  logic [W-1:0] cur_word [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned BC  = (g == 2) ? 4 : 1;
    localparam int unsigned LSB = (g == 1) ? 1 : 0;
    serial_word_tx_if #(.WIDTH(W)) ifc ();
    assign ifc.load_valid = lv[g];
    assign ifc.loadval    = lval[g];
    assign w_sd[g]        = ifc.sdata;
    assign w_busy[g]      = ifc.busy;
    assign w_done[g]      = ifc.done;
    assign w_rdy[g]       = ifc.load_ready;
    serial_word_tx #(.WIDTH(W), .BIT_CYCLES(BC), .LSB_FIRST(LSB)) dut (
      .clk    (clk),
      .rst_n  (rstn[g]),
      .enable (en[g]),
      .bus    (ifc)
    );
  end

  function automatic int bc_of(input int k);
    return (k == 2) ? 4 : 1;
  endfunction

  // Frame position 0 is the start bit, 1..W the data bits, W+1 the stop bit.
  function automatic logic exp_line(input int k);
    int i;
    if (pos[k] < 0)     return 1'b1;
    if (pos[k] == 0)    return 1'b0;
    if (pos[k] == W + 1) return 1'b1;
    i = pos[k] - 1;
    return (k == 1) ? cur_word[k][i] : cur_word[k][W-1-i];
  endfunction

  task automatic check(input string nm, input int k, input logic act, input logic req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t actual=%b required=%b", nm, k, $time, act, req);
    end
  endtask

  task automatic mon_step(input int k);
    logic last;
    logic rdy_exp;
    if (!rstn[k]) begin
      pos[k]      = -1;
      start_nx[k] = 1'b0;
      check("rst_sdata", k, w_sd[k], 1'b1);
      check("rst_busy", k, w_busy[k], 1'b0);
      check("rst_done", k, w_done[k], 1'b0);
      return;
    end
    if (start_nx[k]) begin
      start_nx[k] = 1'b0;
      check("frame_expected", k, exp_q[k].size() > 0, 1'b1);
      if (exp_q[k].size() > 0) cur_word[k] = exp_q[k].pop_front();
      pos[k] = 0;
      cnt[k] = 0;
    end
    last    = (pos[k] == W + 1) && (cnt[k] == bc_of(k) - 1);
    rdy_exp = en[k] && ((pos[k] < 0) || last);
    check("sdata", k, w_sd[k], exp_line(k));
    check("busy", k, w_busy[k], pos[k] >= 0);
    check("done", k, w_done[k], last);
    check("load_ready", k, w_rdy[k], rdy_exp);
    if (rdy_exp && lv[k]) start_nx[k] = 1'b1;
    if ((pos[k] >= 0) && en[k]) begin
      if (cnt[k] == bc_of(k) - 1) begin
        cnt[k] = 0;
        pos[k]++;
        if (pos[k] > W + 1) pos[k] = -1;
      end else begin
        cnt[k]++;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one word; its frame is expected whenever the handshake completes.
  task automatic send(input int k, input logic [W-1:0] w, input bit keep);
    bit ok;
    ok      = 1'b0;
    lv[k]   = 1'b1;
    lval[k] = w;
    exp_q[k].push_back(w);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (w_rdy[k]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep || !ok) lv[k] = 1'b0;
    if (!ok) check("accept_timeout", k, 1'b0, 1'b1);
  endtask

  initial begin
    rstn = '1;
    lv   = '0;
    en   = '1;
    for (int k = 0; k < NI; k++) begin
      lval[k]     = '0;
      pos[k]      = -1;
      cnt[k]      = 0;
      start_nx[k] = 1'b0;
      cur_word[k] = '0;
    end
    #1 rstn = '0;
    fork
      begin
        forever begin
          @(negedge clk);
          for (int k = 0; k < NI; k++) mon_step(k);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 rstn = '1;
        tick(2);
        send(0, 4'b1010, 1'b0);
        tick(10);
        send(1, 4'b1010, 1'b0);
        tick(10);
        send(0, 4'b1010, 1'b1);
        send(0, 4'b0110, 1'b0);
        tick(10);
        send(0, 4'b1010, 1'b0);
        tick(2);
        en[0] = 1'b0;
        tick(3);
        en[0] = 1'b1;
        tick(10);
        send(0, 4'b0110, 1'b0);
        tick(2);
        rstn[0] = 1'b0;
        tick(1);
        rstn[0] = 1'b1;
        tick(3);
        send(0, 4'b1111, 1'b0);
        tick(10);
        send(2, 4'b0011, 1'b0);
        tick(5);
        lval[2] = 4'b1100;
        tick(30);
        for (int k = 0; k < NI; k++) begin
          for (int n = 0; n < 12; n++) begin
            bit keep;
            keep = ($urandom_range(0, 2) == 0) && (n != 11);
            send(k, 4'($urandom_range(0, 15)), keep);
            if (!keep) tick(int'($urandom_range(0, 3)));
          end
          tick(40);
        end
      end
    join_any
    for (int k = 0; k < NI; k++) begin
      check("queue_drained", k, exp_q[k].size() == 0, 1'b1);
      check("line_idle_end", k, w_sd[k], 1'b1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
